// File: rtl/hires_video_generator_pkg.sv
// Shared constants and types for the hi-res video generator.
package video_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DOTS_W  = 7;
  localparam int unsigned HCNT_W  = 7;
  localparam int unsigned VLINE_W = 9;
  localparam int unsigned COLOR_W = 4;

  localparam logic [HCNT_W-1:0]  HSYNC_START = 7'h49;
  localparam logic [HCNT_W-1:0]  HSYNC_END   = 7'h4C;
  localparam logic [VLINE_W-1:0] VSYNC_START = 9'h1E0;
  localparam logic [VLINE_W-1:0] VSYNC_END   = 9'h1E3;

  typedef logic [COLOR_W-1:0] color_t;

  // Rotate a colour window left by 0..3 positions.
  function automatic color_t rotl(input color_t v, input logic [1:0] n);
    logic [2*COLOR_W-1:0] d;
    d = {v, v} << n;
    return d[2*COLOR_W-1:COLOR_W];
  endfunction

endpackage

// File: rtl/hires_video_generator_if.sv
// Video fetch/timing inputs and dot/sync outputs of the hi-res generator.
// Carries color_o only when VIDEO_COLOR_EN is defined.
interface hires_video_if;
  import video_pkg::*;

  logic                 clock_7_i;
  logic                 ld194_i;
  logic [DATA_W-1:0]    video_data_i;
  logic                 hbl_i;
  logic                 vbl_i;
  logic [HCNT_W-1:0]    h_count_i;
  logic [VLINE_W-1:0]   v_line_i;
  logic                 color_ref_i;
  logic                 video_o;
  logic                 blank_o;
  logic                 hsync_o;
  logic                 vsync_o;

`ifdef VIDEO_COLOR_EN
  color_t               color_o;

  modport master (
    output clock_7_i, ld194_i, video_data_i, hbl_i, vbl_i, h_count_i, v_line_i, color_ref_i,
    input  video_o, blank_o, hsync_o, vsync_o, color_o
  );

  modport slave (
    input  clock_7_i, ld194_i, video_data_i, hbl_i, vbl_i, h_count_i, v_line_i, color_ref_i,
    output video_o, blank_o, hsync_o, vsync_o, color_o
  );
`else
  modport master (
    output clock_7_i, ld194_i, video_data_i, hbl_i, vbl_i, h_count_i, v_line_i, color_ref_i,
    input  video_o, blank_o, hsync_o, vsync_o
  );

  modport slave (
    input  clock_7_i, ld194_i, video_data_i, hbl_i, vbl_i, h_count_i, v_line_i, color_ref_i,
    output video_o, blank_o, hsync_o, vsync_o
  );
`endif

endinterface

// File: rtl/hires_video_generator_artifact_color_decoder.sv
// NTSC artifact-colour decoder: a 4-dot window rotated by the colour
// subcarrier phase. Compiled only when VIDEO_COLOR_EN is defined.
`ifdef VIDEO_COLOR_EN
module artifact_color_decoder
  import video_pkg::*;
(
  input  logic   clock_14_i,
  input  logic   reset_n_i,
  input  logic   dot_i,
  input  logic   blank_i,
  input  logic   color_ref_i,
  output color_t color_o
);

  color_t     win;
  color_t     win_next;
  logic [1:0] phase;
  logic       ref_q1;
  logic       ref_q2;

  assign win_next = {dot_i, win[COLOR_W-1:1]};

  // Window, subcarrier phase tracking and registered colour index.
  always_ff @(posedge clock_14_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      win     <= '0;
      phase   <= 2'd0;
      ref_q1  <= 1'b0;
      ref_q2  <= 1'b0;
      color_o <= '0;
    end else begin
      win    <= win_next;
      ref_q1 <= color_ref_i;
      ref_q2 <= ref_q1;
      phase  <= (ref_q1 && !ref_q2) ? 2'd0 : phase + 2'd1;
      // Uses the window including the current dot so latency equals video_o.
      color_o <= blank_i ? color_t'(0) : rotl(win_next, phase);
    end
  end

endmodule
`endif

// File: rtl/hires_video_generator.sv
// Hi-res video generator: 7-dot shifter with bit-7 half-dot delay,
// byte-aligned blanking and delayed H/V sync.
// Optional artifact colour output is built when VIDEO_COLOR_EN is defined.
module hires_video_generator
  import video_pkg::*;
#(
  parameter int unsigned SYNC_DELAY = 2
) (
  input logic         clock_14_i,
  input logic         reset_n_i,
  hires_video_if.slave vif
);

  logic [DOTS_W-1:0]     shreg;
  logic                  dly;
  logic                  blk;
  logic                  raw;
  logic                  raw_d;
  logic                  dot;
  logic                  video_q;
  logic                  blank_q;
  logic                  hs;
  logic                  vs;
  logic [SYNC_DELAY-1:0] hs_sr;
  logic [SYNC_DELAY-1:0] vs_sr;

  assign raw = shreg[0];
  // Half-dot delayed bytes take the previous cycle's dot, bridging the load edge.
  assign dot = dly ? raw_d : raw;

  assign hs = (vif.h_count_i >= HSYNC_START) && (vif.h_count_i <= HSYNC_END);
  assign vs = (vif.v_line_i  >= VSYNC_START) && (vif.v_line_i  <= VSYNC_END);

  // Byte load (priority) and 7M dot shift with zero fill.
  always_ff @(posedge clock_14_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shreg <= '0;
      dly   <= 1'b0;
      blk   <= 1'b0;
    end else if (!vif.ld194_i) begin
      shreg <= vif.video_data_i[DOTS_W-1:0];
      dly   <= vif.video_data_i[DATA_W-1];
      blk   <= vif.hbl_i | vif.vbl_i;
    end else if (vif.clock_7_i) begin
      shreg <= {1'b0, shreg[DOTS_W-1:1]};
    end
  end

  // Half-dot delay tap and registered dot/blank outputs.
  always_ff @(posedge clock_14_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      raw_d   <= 1'b0;
      video_q <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      raw_d   <= raw;
      video_q <= dot & ~blk;
      blank_q <= blk;
    end
  end

  // Sync delay lines keep sync in step with the dot pipeline.
  always_ff @(posedge clock_14_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      hs_sr <= SYNC_DELAY'({hs_sr, hs});
      vs_sr <= SYNC_DELAY'({vs_sr, vs});
    end
  end

  assign vif.video_o = video_q;
  assign vif.blank_o = blank_q;
  assign vif.hsync_o = hs_sr[SYNC_DELAY-1];
  assign vif.vsync_o = vs_sr[SYNC_DELAY-1];

`ifdef VIDEO_COLOR_EN
  color_t color_q;

  artifact_color_decoder u_color (
    .clock_14_i  (clock_14_i),
    .reset_n_i   (reset_n_i),
    .dot_i       (dot),
    .blank_i     (blk),
    .color_ref_i (vif.color_ref_i),
    .color_o     (color_q)
  );

  assign vif.color_o = color_q;
`else
  // Colour reference has no consumer in the monochrome build.
  logic unused_color_ref;
  assign unused_color_ref = vif.color_ref_i;
`endif

endmodule
